// File: rtl/load_store_unit_if.sv
// Core-side request/response channel and data-memory port of the load/store unit.
// master drives the transaction (core on req, LSU on mem); slave answers it.
interface lsu_req_if #(parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (output req_valid, req_write, req_addr, req_wdata, req_funct3,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_funct3,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 64);
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [63:0]       mem_read_data;

  modport master (output mem_addr, mem_write_data, mem_write, mem_read,
                  input  mem_read_data);
  modport slave  (input  mem_addr, mem_write_data, mem_write, mem_read,
                  output mem_read_data);
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns B/H/W/D core accesses into aligned 64-bit memory cycles,
// with read-modify-write for sub-word stores and sign/zero-extended loads.
module load_store_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  typedef struct packed {
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
  } lat_t;

  state_t      state_q, state_d;
  lat_t        lat_q, lat_d;
  logic [63:0] merge_q, merge_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic              bad;
  logic [2:0]        off;
  logic [63:0]       rd_sh, wr_sh, ld_ext;
  logic [7:0]        lane_mask, byte_en;
  logic [NB-1:0][7:0] merged;

  always_comb begin
    bad = (req.req_funct3 == 3'b111) || (req.req_write && req.req_funct3[2]);
    case (req.req_funct3[1:0])
      2'b01:   bad = bad || req.req_addr[0];
      2'b10:   bad = bad || (|req.req_addr[1:0]);
      2'b11:   bad = bad || (|req.req_addr[2:0]);
      default: ;
    endcase
  end

  assign off   = lat_q.addr[2:0];
  assign rd_sh = mem.mem_read_data >> {off, 3'b000};
  assign wr_sh = lat_q.wdata << {off, 3'b000};

  always_comb begin
    ld_ext    = rd_sh;
    lane_mask = 8'hFF;
    case (lat_q.funct3[1:0])
      2'b00: begin
        lane_mask = 8'h01;
        ld_ext    = lat_q.funct3[2] ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
      end
      2'b01: begin
        lane_mask = 8'h03;
        ld_ext    = lat_q.funct3[2] ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
      end
      2'b10: begin
        lane_mask = 8'h0F;
        ld_ext    = lat_q.funct3[2] ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
      end
      default: ;
    endcase
  end

  // Aligned accesses never carry lanes past byte 7, so truncation is safe.
  assign byte_en = 8'(lane_mask << off);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign merged[i] = byte_en[i] ? wr_sh[8*i +: 8] : mem.mem_read_data[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req.req_valid) begin
        lat_d = '{funct3: req.req_funct3, addr: req.req_addr, wdata: req.req_wdata};
        if (bad) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (!req.req_write)         state_d = LOAD;
        else if (req.req_funct3 == 3'b011)   state_d = WRITE;
        else                                 state_d = RMW_READ;
      end
      LOAD: begin
        rdata_d = ld_ext;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RMW_READ: begin
        merge_d = merged;
        state_d = WRITE;
      end
      WRITE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req.req_ready      = (state_q == IDLE);
  assign req.resp_valid     = (state_q == RESP);
  assign req.resp_rdata     = rdata_q;
  assign req.resp_err       = err_q;
  assign mem.mem_addr       = {lat_q.addr[ADDR_W-1:3], 3'b000};
  assign mem.mem_read       = (state_q == LOAD) || (state_q == RMW_READ);
  assign mem.mem_write      = (state_q == WRITE);
  // Full-word stores skip the read, so the merge buffer is bypassed.
  assign mem.mem_write_data = (lat_q.funct3[1:0] == 2'b11) ? lat_q.wdata : merge_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-bit word RAM.
module tb_load_store_unit;
  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  always #5 clk = ~clk;

  lsu_req_if #(.ADDR_W(ADDR_W)) req_if ();
  lsu_mem_if #(.ADDR_W(ADDR_W)) mem_if ();

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_if.slave),
    .mem (mem_if.master)
  );

  logic [63:0] mem [0:255];
  assign mem_if.mem_read_data = mem[mem_if.mem_addr[10:3]];

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[2] <= 64'h8877665544332211;
    end else if (mem_if.mem_write) begin
      mem[mem_if.mem_addr[10:3]] <= mem_if.mem_write_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  int          rd_cyc, wr_cyc, resp_cyc, n_rd, n_wr;
  logic [63:0] r_data, w_addr, w_data;
  logic        r_err;

  task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [2:0] f3);
    rd_cyc = -1; wr_cyc = -1; resp_cyc = -1; n_rd = 0; n_wr = 0;
    r_data = 'x; r_err = 1'bx; w_addr = 'x; w_data = 'x;
    @(negedge clk);
    req_if.req_valid  = 1'b1;
    req_if.req_write  = wr;
    req_if.req_addr   = addr;
    req_if.req_wdata  = wdata;
    req_if.req_funct3 = f3;
    chk("ready", req_if.req_ready, 1'b1);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    for (int c = 1; c <= 6 && resp_cyc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_if.mem_read) begin
        n_rd++;
        if (rd_cyc < 0) rd_cyc = c;
      end
      if (mem_if.mem_write) begin
        n_wr++;
        wr_cyc = c;
        w_addr = mem_if.mem_addr;
        w_data = mem_if.mem_write_data;
      end
      if (req_if.resp_valid) begin
        resp_cyc = c;
        r_data   = req_if.resp_rdata;
        r_err    = req_if.resp_err;
      end
    end
    @(negedge clk);
    chk("resp_pulse", req_if.resp_valid, 1'b0);
  endtask

  task automatic load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                      input logic [63:0] exp);
    txn(1'b0, addr, '0, f3);
    chk({tag, "_rd_cyc"}, rd_cyc, 1);
    chk({tag, "_resp_cyc"}, resp_cyc, 2);
    chk({tag, "_data"}, r_data, exp);
    chk({tag, "_err"}, r_err, 1'b0);
    chk({tag, "_nwr"}, n_wr, 0);
  endtask

  task automatic bad(input string tag, input logic wr, input logic [63:0] addr,
                     input logic [2:0] f3);
    txn(wr, addr, 64'h1234, f3);
    chk({tag, "_resp_cyc"}, resp_cyc, 1);
    chk({tag, "_err"}, r_err, 1'b1);
    chk({tag, "_data"}, r_data, 64'h0);
    chk({tag, "_nrd"}, n_rd, 0);
    chk({tag, "_nwr"}, n_wr, 0);
  endtask

  initial begin
    req_if.req_valid  = 1'b0;
    req_if.req_write  = 1'b0;
    req_if.req_addr   = '0;
    req_if.req_wdata  = '0;
    req_if.req_funct3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_if.req_ready, 1'b1);
    chk("rst_resp_valid", req_if.resp_valid, 1'b0);
    chk("rst_rdata", req_if.resp_rdata, 64'h0);
    chk("rst_err", req_if.resp_err, 1'b0);
    chk("rst_mem_addr", mem_if.mem_addr, 64'h0);
    chk("rst_mem_wdata", mem_if.mem_write_data, 64'h0);
    chk("rst_mem_write", mem_if.mem_write, 1'b0);
    chk("rst_mem_read", mem_if.mem_read, 1'b0);
    rst  = 1'b0;
    init = 1'b0;

    load("lb",  64'h17, 3'b000, 64'hFFFFFFFFFFFFFF88);
    load("lbu", 64'h17, 3'b100, 64'h0000000000000088);
    load("lh",  64'h16, 3'b001, 64'hFFFFFFFFFFFF8877);
    load("lw",  64'h14, 3'b010, 64'hFFFFFFFF88776655);
    load("lwu", 64'h14, 3'b110, 64'h0000000088776655);
    load("ld",  64'h10, 3'b011, 64'h8877665544332211);

    txn(1'b1, 64'h11, 64'hFFAB, 3'b000);
    chk("sb_rd_cyc", rd_cyc, 1);
    chk("sb_wr_cyc", wr_cyc, 2);
    chk("sb_nwr", n_wr, 1);
    chk("sb_addr", w_addr, 64'h10);
    chk("sb_wdata", w_data, 64'h887766554433AB11);
    chk("sb_resp_cyc", resp_cyc, 3);
    chk("sb_rdata", r_data, 64'h0);
    chk("sb_err", r_err, 1'b0);
    load("ld_after_sb", 64'h10, 3'b011, 64'h887766554433AB11);

    txn(1'b1, 64'h20, 64'hDEADBEEF00000000, 3'b011);
    chk("sd_wr_cyc", wr_cyc, 1);
    chk("sd_nrd", n_rd, 0);
    chk("sd_nwr", n_wr, 1);
    chk("sd_wdata", w_data, 64'hDEADBEEF00000000);
    chk("sd_resp_cyc", resp_cyc, 2);
    load("ld_after_sd", 64'h20, 3'b011, 64'hDEADBEEF00000000);

    txn(1'b1, 64'h1C, 64'hCAFEF00D, 3'b010);
    chk("sw_addr", w_addr, 64'h18);
    chk("sw_wdata", w_data, 64'hCAFEF00D00000000);
    chk("sw_resp_cyc", resp_cyc, 3);
    load("lh_hi", 64'h1E, 3'b001, 64'hFFFFFFFFFFFFCAFE);
    load("lhu",   64'h1C, 3'b101, 64'h000000000000F00D);

    bad("err_lw_mis", 1'b0, 64'h12, 3'b010);
    bad("err_sh_mis", 1'b1, 64'h13, 3'b001);
    bad("err_f3_111", 1'b0, 64'h10, 3'b111);
    bad("err_st_u",   1'b1, 64'h10, 3'b100);
    load("ld_after_err", 64'h10, 3'b011, 64'h887766554433AB11);

    // Reset lands while the store is in its read phase.
    @(negedge clk);
    req_if.req_valid  = 1'b1;
    req_if.req_write  = 1'b1;
    req_if.req_addr   = 64'h11;
    req_if.req_wdata  = 64'h55;
    req_if.req_funct3 = 3'b000;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    chk("rr_in_rmw", mem_if.mem_read, 1'b1);
    rst = 1'b1;
    n_wr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_if.mem_write) n_wr++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_if.mem_write) n_wr++;
      chk("rr_resp_valid", req_if.resp_valid, 1'b0);
    end
    chk("rr_nwr", n_wr, 0);
    chk("rr_ready", req_if.req_ready, 1'b1);
    chk("rr_mem_word", mem[2], 64'h887766554433AB11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
